clk_div_ctrl: RTL

- Run-time controller for the board's clock-divider path: produces a divided square wave `clk_out` and a one-cycle `tick` strobe from the 50 MHz system clock.
- Divisor is loaded at run time through a valid/ready config port. Changes take effect glitch-free, only at a period boundary.
- Supports clean start/stop through an enable input. Replaces fixed-ratio dividers where software or other blocks must change or pause the output rate.

---
 rtl/clk_div_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/clk_div_ctrl.sv
// Run-time programmable clock divider: produces a 50%-duty clk_out and a
// rise-aligned tick. Divisor changes and stops take effect only at period boundaries.
module clk_div_ctrl #(
    parameter int CNT_W        = 26,
    parameter int DEFAULT_HALF = 25000000
) (
    input  logic             clk_50mHz,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] cur_half
);

    localparam logic [CNT_W-1:0] RESET_HALF = CNT_W'(DEFAULT_HALF);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] cur_nx;
    logic [CNT_W-1:0] pend_half, pend_half_nx;
    logic             pend_valid, pend_valid_nx;
    logic             clk_nx, tick_nx;
    logic             terminal;

    assign terminal  = (cnt == cur_half - CNT_W'(1));
    assign cfg_ready = !pend_valid;
    assign busy      = (state != IDLE);

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        clk_nx        = clk_out;
        tick_nx       = 1'b0;
        cur_nx        = cur_half;
        pend_valid_nx = pend_valid;
        pend_half_nx  = pend_half;

        case (state)
            IDLE: begin
                cnt_nx = '0;
                clk_nx = 1'b0;
                if (pend_valid) begin
                    cur_nx        = pend_half;
                    pend_valid_nx = 1'b0;
                end
                if (en) state_nx = RUN;
            end

            RUN, STOP: begin
                if (terminal) begin
                    cnt_nx  = '0;
                    clk_nx  = !clk_out;
                    tick_nx = !clk_out;
                    // Divisor swaps only at the falling boundary so no period is ever cut short.
                    if (clk_out && pend_valid) begin
                        cur_nx        = pend_half;
                        pend_valid_nx = 1'b0;
                    end
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end

                if (state == RUN && !en) begin
                    if (clk_out) begin
                        state_nx = terminal ? IDLE : STOP;
                    end else if (terminal) begin
                        state_nx = STOP;
                    end else begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end else if (state == STOP && terminal) begin
                    state_nx = IDLE;
                end
            end

            default: state_nx = IDLE;
        endcase

        // The slot can only accept when empty, so this never collides with an apply.
        if (cfg_valid && !pend_valid) begin
            pend_valid_nx = 1'b1;
            pend_half_nx  = (cfg_half == '0) ? CNT_W'(1) : cfg_half;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above.
    always_ff @(posedge clk_50mHz) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
            cur_half   <= RESET_HALF;
            pend_valid <= 1'b0;
            pend_half  <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            clk_out    <= clk_nx;
            tick       <= tick_nx;
            cur_half   <= cur_nx;
            pend_valid <= pend_valid_nx;
            pend_half  <= pend_half_nx;
        end
    end

endmodule
